// File: rtl/dlx_prog_loader_if.sv
// Byte-stream handshake and instruction-memory write port of the DLX program loader.
// The master side is the byte source / memory sink, the slave side is the loader itself.
interface dlx_prog_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );
endinterface

// File: rtl/dlx_prog_loader.sv
// Boot-time DLX program loader: length-prefixed byte stream -> big-endian words in
// instruction memory, XOR checksum verified, core held in reset until a good load.
module dlx_prog_loader #(
    parameter logic [15:0] DEPTH_WORDS = 16'd64,
    parameter logic [31:0] BASE_ADDR   = 32'd0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    dlx_prog_loader_if.slave    bus,
    output logic                core_hold,
    output logic                load_done,
    output logic                load_error,
    output logic [15:0]         words_loaded
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } state_t;

    state_t      state_r;
    state_t      next_state_s;

    logic [1:0]  byte_idx_r;
    logic [15:0] len_r;
    logic [15:0] word_cnt_r;
    logic [7:0]  csum_r;
    logic [23:0] part_r;

    logic        byte_ready_r;
    logic        imem_we_r;
    logic [31:0] imem_addr_r;
    logic [31:0] imem_wdata_r;
    logic        core_hold_r;
    logic        load_done_r;
    logic        load_error_r;
    logic [15:0] words_loaded_r;

    logic        accept_s;
    logic        restart_s;
    logic [15:0] len_s;
    logic        word_end_s;
    logic [15:0] word_cnt_nxt_s;
    logic        ready_nxt_s;

    assign accept_s       = bus.byte_valid & byte_ready_r;
    assign restart_s      = start & ((state_r == IDLE) | (state_r == DONE) | (state_r == ERROR));
    assign len_s          = {len_r[15:8], bus.byte_data};
    assign word_end_s     = accept_s & (state_r == DATA) & (byte_idx_r == 2'd3);
    assign word_cnt_nxt_s = word_end_s ? (word_cnt_r + 16'd1) : word_cnt_r;

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) next_state_s = LEN_HI;
                else       next_state_s = IDLE;
            end
            LEN_HI: begin
                if (accept_s) next_state_s = LEN_LO;
                else          next_state_s = LEN_HI;
            end
            LEN_LO: begin
                if (!accept_s)                next_state_s = LEN_LO;
                else if (len_s > DEPTH_WORDS) next_state_s = ERROR;
                else if (len_s == 16'd0)      next_state_s = CSUM;
                else                          next_state_s = DATA;
            end
            DATA: begin
                // leave only once the last word's write pulse is on the bus
                if (imem_we_r && (word_cnt_r == len_r)) next_state_s = CSUM;
                else                                    next_state_s = DATA;
            end
            CSUM: begin
                if (!accept_s)                   next_state_s = CSUM;
                else if (bus.byte_data == csum_r) next_state_s = DONE;
                else                              next_state_s = ERROR;
            end
            DONE, ERROR: begin
                if (start) next_state_s = LEN_HI;
                else       next_state_s = state_r;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Registered byte_ready: closed once every data byte of the load has been taken
    always_comb begin
        ready_nxt_s = 1'b0;
        case (next_state_s)
            LEN_HI, LEN_LO, CSUM: ready_nxt_s = 1'b1;
            DATA: begin
                if ((state_r != DATA) || (word_cnt_nxt_s != len_r)) ready_nxt_s = 1'b1;
                else                                               ready_nxt_s = 1'b0;
            end
            default: ready_nxt_s = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) state_r <= IDLE;
        else       state_r <= next_state_s;
    end

    // Datapath: length capture, word packing, checksum, write port and status
    always_ff @(posedge clock) begin
        if (reset) begin
            byte_idx_r     <= 2'd0;
            len_r          <= 16'd0;
            word_cnt_r     <= 16'd0;
            csum_r         <= 8'd0;
            part_r         <= 24'd0;
            byte_ready_r   <= 1'b0;
            imem_we_r      <= 1'b0;
            imem_addr_r    <= BASE_ADDR;
            imem_wdata_r   <= 32'd0;
            core_hold_r    <= 1'b1;
            load_done_r    <= 1'b0;
            load_error_r   <= 1'b0;
            words_loaded_r <= 16'd0;
        end else begin
            byte_ready_r <= ready_nxt_s;
            imem_we_r    <= 1'b0;
            core_hold_r  <= ~((state_r == DONE) & ~restart_s);
            if (restart_s) begin
                byte_idx_r     <= 2'd0;
                len_r          <= 16'd0;
                word_cnt_r     <= 16'd0;
                csum_r         <= 8'd0;
                part_r         <= 24'd0;
                imem_addr_r    <= BASE_ADDR;
                imem_wdata_r   <= 32'd0;
                load_done_r    <= 1'b0;
                load_error_r   <= 1'b0;
                words_loaded_r <= 16'd0;
            end else begin
                if (next_state_s == DONE)  load_done_r  <= 1'b1;
                if (next_state_s == ERROR) load_error_r <= 1'b1;
                case (state_r)
                    LEN_HI: if (accept_s) len_r[15:8] <= bus.byte_data;
                    LEN_LO: if (accept_s) len_r[7:0]  <= bus.byte_data;
                    DATA: begin
                        if (accept_s) begin
                            csum_r     <= csum_r ^ bus.byte_data;
                            byte_idx_r <= byte_idx_r + 2'd1;
                            if (byte_idx_r == 2'd3) begin
                                imem_we_r      <= 1'b1;
                                imem_wdata_r   <= {part_r, bus.byte_data};
                                imem_addr_r    <= BASE_ADDR + {14'd0, word_cnt_r, 2'b00};
                                words_loaded_r <= word_cnt_r + 16'd1;
                                word_cnt_r     <= word_cnt_r + 16'd1;
                            end else begin
                                part_r <= {part_r[15:0], bus.byte_data};
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.byte_ready = byte_ready_r;
    assign bus.imem_we    = imem_we_r;
    assign bus.imem_addr  = imem_addr_r;
    assign bus.imem_wdata = imem_wdata_r;
    assign core_hold      = core_hold_r;
    assign load_done      = load_done_r;
    assign load_error     = load_error_r;
    assign words_loaded   = words_loaded_r;

endmodule
